// File: rtl/spi_ext_mem_ctrl.sv
// SPI mode-0 master issuing READ (0x03) / WRITE (0x02) bursts to a serial SRAM.
// One request at a time; the device auto-increments the address across a burst.
module spi_ext_mem_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 20,
   parameter int ADDR_BYTES = 3,
   parameter int CLK_DIV    = 2,
   parameter int MAX_BURST  = 16,
   parameter int LEN_W      = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_we,
   input  logic                  req_re,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [LEN_W-1:0]      req_len,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  wr_ack,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [ADDR_WIDTH-1:0] cur_addr,
   output logic                  spi_sclk,
   output logic                  spi_cs_n,
   output logic                  spi_mosi,
   input  logic                  spi_miso
);

   localparam int ABITS    = 8 * ADDR_BYTES;
   localparam int HDR_BITS = 8 + ABITS;
   localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W    = $clog2(HDR_BITS + DATA_WIDTH + 1);

   typedef enum logic [2:0] {
      IDLE, CS_SETUP, CMD, ADDR, DATA, CS_HOLD, DONE
   } state_t;

   state_t state, next_state;

   logic [DIV_W-1:0]      div_cnt;
   logic [BIT_W-1:0]      bit_cnt;
   logic [LEN_W-1:0]      len_q;
   logic [LEN_W-1:0]      word_cnt;
   logic                  is_read;
   logic [HDR_BITS-1:0]   hdr_sr;
   logic [DATA_WIDTH-1:0] wr_sr;
   logic [DATA_WIDTH-1:0] rd_sr;

   logic                  len_ok;
   logic                  accept;
   logic                  reject;
   logic                  shifting;
   logic                  tick;
   logic                  rise;
   logic                  fall;
   logic                  last_bit;
   logic                  last_word;
   logic [7:0]            cmd;
   logic [DATA_WIDTH-1:0] wr_next;
   logic [DATA_WIDTH-1:0] rd_next;

   assign len_ok    = (req_len != '0) && (req_len <= LEN_W'(MAX_BURST));
   assign accept    = (state == IDLE) && (req_we ^ req_re) && len_ok;
   assign reject    = (state == IDLE) && (req_we | req_re) && !accept;
   assign shifting  = (state == CMD) || (state == ADDR) || (state == DATA);
   assign tick      = (div_cnt == DIV_W'(CLK_DIV - 1));
   assign rise      = shifting && tick && !spi_sclk;
   assign fall      = shifting && tick && spi_sclk;
   assign last_word = (word_cnt == len_q - LEN_W'(1));
   assign cmd       = req_re ? 8'h03 : 8'h02;
   assign wr_next   = wr_sr << 1;
   assign rd_next   = DATA_WIDTH'({rd_sr, spi_miso});

   always_comb begin
      last_bit = 1'b0;
      case (state)
         CMD:     last_bit = (bit_cnt == BIT_W'(7));
         ADDR:    last_bit = (bit_cnt == BIT_W'(ABITS - 1));
         DATA:    last_bit = (bit_cnt == BIT_W'(DATA_WIDTH - 1));
         default: last_bit = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= next_state;
   end

   // Phase changes happen only on the falling SCLK transition that ends a bit.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:     if (accept) next_state = CS_SETUP;
         CS_SETUP: if (tick) next_state = CMD;
         CMD:      if (fall && last_bit) next_state = ADDR;
         ADDR:     if (fall && last_bit) next_state = DATA;
         DATA:     if (fall && last_bit && last_word) next_state = CS_HOLD;
         CS_HOLD:  if (tick) next_state = DONE;
         DONE:     next_state = IDLE;
         default:  next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_cnt  <= '0;
         bit_cnt  <= '0;
         len_q    <= '0;
         word_cnt <= '0;
         is_read  <= 1'b0;
         hdr_sr   <= '0;
         wr_sr    <= '0;
         rd_sr    <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
         wr_ack   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         cur_addr <= '0;
         spi_sclk <= 1'b0;
         spi_cs_n <= 1'b1;
         spi_mosi <= 1'b0;
      end else begin
         wr_ack   <= 1'b0;
         rd_valid <= 1'b0;
         err      <= reject;
         done     <= (next_state == DONE);
         busy     <= (next_state != IDLE) && (next_state != DONE);
         spi_cs_n <= (next_state == IDLE) || (next_state == DONE);

         if ((state == IDLE) || (state == DONE) || tick) div_cnt <= '0;
         else                                            div_cnt <= div_cnt + DIV_W'(1);

         if (accept) begin
            len_q    <= req_len;
            is_read  <= req_re;
            hdr_sr   <= {cmd, ABITS'(req_addr)};
            wr_sr    <= wr_data;
            wr_ack   <= req_we;
            cur_addr <= req_addr;
            bit_cnt  <= '0;
            word_cnt <= '0;
            spi_sclk <= 1'b0;
            spi_mosi <= cmd[7];
         end

         if (rise) begin
            spi_sclk <= 1'b1;
            if (state == DATA && is_read) begin
               rd_sr <= rd_next;
               if (last_bit) begin
                  rd_data  <= rd_next;
                  rd_valid <= 1'b1;
               end
            end
         end

         // Falling edge: advance the bit and present the next MOSI bit.
         if (fall) begin
            spi_sclk <= 1'b0;
            bit_cnt  <= last_bit ? '0 : bit_cnt + BIT_W'(1);
            if (state == DATA) begin
               if (last_bit) begin
                  cur_addr <= cur_addr + ADDR_WIDTH'(1);
                  word_cnt <= word_cnt + LEN_W'(1);
                  if (!last_word && !is_read) begin
                     wr_sr    <= wr_data;
                     wr_ack   <= 1'b1;
                     spi_mosi <= wr_data[DATA_WIDTH-1];
                  end else begin
                     spi_mosi <= 1'b0;
                  end
               end else begin
                  wr_sr    <= wr_next;
                  spi_mosi <= !is_read && wr_next[DATA_WIDTH-1];
               end
            end else if (state == ADDR && last_bit) begin
               spi_mosi <= !is_read && wr_sr[DATA_WIDTH-1];
            end else begin
               hdr_sr   <= hdr_sr << 1;
               spi_mosi <= hdr_sr[HDR_BITS-2];
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_ext_mem_ctrl.sv
// Directed bench for spi_ext_mem_ctrl with a behavioural mode-0 serial SRAM model.
module tb_spi_ext_mem_ctrl;

   localparam int DW = 8;
   localparam int AW = 20;
   localparam int LW = 5;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          req_we = 1'b0;
   logic          req_re = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [LW-1:0] req_len = '0;
   logic [DW-1:0] wr_data;
   logic          wr_ack;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          busy;
   logic          done;
   logic          err;
   logic [AW-1:0] cur_addr;
   logic          spi_sclk;
   logic          spi_cs_n;
   logic          spi_mosi;
   logic          spi_miso = 1'b0;

   int compared = 0;
   int mismatched = 0;

   int wr_ack_cnt = 0, rd_valid_cnt = 0, done_cnt = 0, err_cnt = 0;
   int busy_cnt = 0, cs_low_cnt = 0, rx_bits = 0, wr_base = 0;
   logic          mosi_bits [0:511];
   logic [7:0]    wr_words [0:15];
   logic [7:0]    slave_words [0:15];
   logic [7:0]    rd_log [0:63];
   logic [AW-1:0] rd_addr_log [0:63];
   logic [AW-1:0] ack_addr_log [0:63];
   logic          prev_sclk = 1'b0, prev_cs = 1'b1, cs_at_done = 1'b0;

   always #5 clk = ~clk;

   assign wr_data = wr_words[(wr_ack_cnt - wr_base) & 15];

   spi_ext_mem_ctrl dut (
      .clk(clk), .reset(reset), .req_we(req_we), .req_re(req_re),
      .req_addr(req_addr), .req_len(req_len), .wr_data(wr_data), .wr_ack(wr_ack),
      .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done), .err(err),
      .cur_addr(cur_addr), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
      .spi_mosi(spi_mosi), .spi_miso(spi_miso)
   );

   // Serial SRAM model and pulse bookkeeping; sampled mid-cycle, away from the active edge.
   always @(negedge clk) begin
      int d;
      if (prev_cs && !spi_cs_n) begin
         rx_bits  = 0;
         spi_miso = 1'b0;
      end
      if (!spi_cs_n) cs_low_cnt++;
      if (!spi_cs_n && spi_sclk && !prev_sclk) begin
         if (rx_bits < 512) mosi_bits[rx_bits] = spi_mosi;
         rx_bits++;
      end
      if (!spi_cs_n && !spi_sclk && prev_sclk && rx_bits >= 32) begin
         d = rx_bits - 32;
         spi_miso = slave_words[(d / 8) & 15][7 - (d % 8)];
      end
      if (wr_ack) begin
         ack_addr_log[wr_ack_cnt & 63] = cur_addr;
         wr_ack_cnt++;
      end
      if (rd_valid) begin
         rd_log[rd_valid_cnt & 63]      = rd_data;
         rd_addr_log[rd_valid_cnt & 63] = cur_addr;
         rd_valid_cnt++;
      end
      if (done) begin
         cs_at_done = spi_cs_n;
         done_cnt++;
      end
      if (err) err_cnt++;
      if (busy) busy_cnt++;
      prev_sclk = spi_sclk;
      prev_cs   = spi_cs_n;
   end

   function automatic logic [31:0] bits_at(input int start, input int n);
      logic [31:0] v = '0;
      for (int i = 0; i < n; i++) v = {v[30:0], mosi_bits[start + i]};
      return v;
   endfunction

   task automatic issue(input logic we, input logic re, input logic [AW-1:0] addr,
                        input logic [LW-1:0] len);
      @(posedge clk); #1;
      req_we = we; req_re = re; req_addr = addr; req_len = len;
      @(posedge clk); #1;
      req_we = 1'b0; req_re = 1'b0;
   endtask

   task automatic wait_done(input int base, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk); #1;
         if (done_cnt > base) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      #1;
      compared++;
      if ({spi_cs_n, spi_sclk, spi_mosi} !== 3'b100) begin
         mismatched++;
         $display("[TB] FAIL reset_spi_pins: got %b required 100", {spi_cs_n, spi_sclk, spi_mosi});
      end
      compared++;
      if ({busy, done, err, wr_ack, rd_valid} !== 5'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_status: got %b required 00000", {busy, done, err, wr_ack, rd_valid});
      end
      compared++;
      if (rd_data !== 8'h00 || cur_addr !== 20'h0) begin
         mismatched++;
         $display("[TB] FAIL reset_data: rd_data %h cur_addr %h required 00 00000", rd_data, cur_addr);
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_write_single();
      int d0 = done_cnt, a0 = wr_ack_cnt, e0 = err_cnt, c0 = cs_low_cnt;
      bit ok;
      wr_words[0] = 8'hA5;
      wr_base = wr_ack_cnt;
      issue(1'b1, 1'b0, 20'h00010, 5'd1);
      wait_done(d0, 2000, ok);
      compared++;
      if (!ok) begin mismatched++; $display("[TB] FAIL wr1_timeout: no done within budget"); end
      compared++;
      if (bits_at(0, 8) !== 32'h02 || bits_at(8, 24) !== 32'h000010 || bits_at(32, 8) !== 32'hA5) begin
         mismatched++;
         $display("[TB] FAIL wr1_mosi: got %h %h %h required 02 000010 a5",
                  bits_at(0, 8), bits_at(8, 24), bits_at(32, 8));
      end
      compared++;
      if (rx_bits !== 40) begin mismatched++; $display("[TB] FAIL wr1_bits: got %0d required 40", rx_bits); end
      compared++;
      if (cs_low_cnt - c0 !== 164) begin
         mismatched++; $display("[TB] FAIL wr1_cs_low: got %0d required 164", cs_low_cnt - c0);
      end
      compared++;
      if (wr_ack_cnt - a0 !== 1 || done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
         mismatched++;
         $display("[TB] FAIL wr1_pulses: ack %0d done %0d err %0d required 1 1 0",
                  wr_ack_cnt - a0, done_cnt - d0, err_cnt - e0);
      end
   endtask

   task automatic test_read_single();
      int d0 = done_cnt, r0 = rd_valid_cnt, c0 = cs_low_cnt;
      bit ok;
      slave_words[0] = 8'hA5;
      issue(1'b0, 1'b1, 20'h00010, 5'd1);
      wait_done(d0, 2000, ok);
      compared++;
      if (!ok) begin mismatched++; $display("[TB] FAIL rd1_timeout: no done within budget"); end
      compared++;
      if (bits_at(0, 8) !== 32'h03 || bits_at(8, 24) !== 32'h000010) begin
         mismatched++;
         $display("[TB] FAIL rd1_mosi: got %h %h required 03 000010", bits_at(0, 8), bits_at(8, 24));
      end
      compared++;
      if (rd_valid_cnt - r0 !== 1 || rd_log[r0 & 63] !== 8'hA5) begin
         mismatched++;
         $display("[TB] FAIL rd1_data: pulses %0d data %h required 1 a5", rd_valid_cnt - r0, rd_log[r0 & 63]);
      end
      compared++;
      if (cs_at_done !== 1'b1 || cs_low_cnt - c0 !== 164) begin
         mismatched++;
         $display("[TB] FAIL rd1_cs: cs_n at done %b low %0d required 1 164", cs_at_done, cs_low_cnt - c0);
      end
   endtask

   task automatic test_burst_read();
      int d0 = done_cnt, r0 = rd_valid_cnt, c0 = cs_low_cnt;
      logic [7:0] exp_data [0:3] = '{8'h11, 8'h22, 8'h33, 8'h44};
      bit ok;
      for (int i = 0; i < 4; i++) slave_words[i] = exp_data[i];
      issue(1'b0, 1'b1, 20'h00020, 5'd4);
      wait_done(d0, 3000, ok);
      compared++;
      if (!ok) begin mismatched++; $display("[TB] FAIL rd4_timeout: no done within budget"); end
      compared++;
      if (rd_valid_cnt - r0 !== 4) begin
         mismatched++; $display("[TB] FAIL rd4_count: got %0d required 4", rd_valid_cnt - r0);
      end
      for (int i = 0; i < 4; i++) begin
         compared++;
         if (rd_log[(r0 + i) & 63] !== exp_data[i] || rd_addr_log[(r0 + i) & 63] !== 20'h00020 + 20'(i)) begin
            mismatched++;
            $display("[TB] FAIL rd4_word%0d: data %h addr %h required %h %h", i,
                     rd_log[(r0 + i) & 63], rd_addr_log[(r0 + i) & 63], exp_data[i], 20'h00020 + 20'(i));
         end
      end
      compared++;
      if (cur_addr !== 20'h00024 || cs_low_cnt - c0 !== 260) begin
         mismatched++;
         $display("[TB] FAIL rd4_end: cur_addr %h cs_low %0d required 00024 260", cur_addr, cs_low_cnt - c0);
      end
   endtask

   task automatic test_reject();
      logic [1:0] strobes [0:2] = '{2'b11, 2'b10, 2'b01};
      logic [4:0] lens [0:2]    = '{5'd1, 5'd0, 5'd17};
      for (int i = 0; i < 3; i++) begin
         int e0 = err_cnt, c0 = cs_low_cnt, b0 = busy_cnt;
         issue(strobes[i][1], strobes[i][0], 20'h00100, lens[i]);
         repeat (4) @(negedge clk);
         #1;
         compared++;
         if (err_cnt - e0 !== 1 || cs_low_cnt - c0 !== 0 || busy_cnt - b0 !== 0) begin
            mismatched++;
            $display("[TB] FAIL reject%0d: err %0d cs_low %0d busy %0d required 1 0 0",
                     i, err_cnt - e0, cs_low_cnt - c0, busy_cnt - b0);
         end
      end
   endtask

   task automatic test_busy_ignore();
      int d0 = done_cnt, e0 = err_cnt, a0 = wr_ack_cnt, c0 = cs_low_cnt;
      bit ok;
      slave_words[0] = 8'h96;
      issue(1'b0, 1'b1, 20'h00200, 5'd1);
      repeat (20) @(posedge clk);
      issue(1'b1, 1'b1, 20'h00300, 5'd1);
      issue(1'b1, 1'b0, 20'h00300, 5'd2);
      wait_done(d0, 2000, ok);
      repeat (20) @(negedge clk);
      #1;
      compared++;
      if (!ok || done_cnt - d0 !== 1 || err_cnt - e0 !== 0 || wr_ack_cnt - a0 !== 0 || cs_low_cnt - c0 !== 164) begin
         mismatched++;
         $display("[TB] FAIL busy_ignore: ok %0d done %0d err %0d ack %0d cs_low %0d required 1 1 0 0 164",
                  ok, done_cnt - d0, err_cnt - e0, wr_ack_cnt - a0, cs_low_cnt - c0);
      end
   endtask

   task automatic test_burst_write_wrap();
      int d0 = done_cnt, a0 = wr_ack_cnt;
      bit ok;
      wr_words[0] = 8'h5A;
      wr_words[1] = 8'hC3;
      wr_base = wr_ack_cnt;
      issue(1'b1, 1'b0, 20'hFFFFF, 5'd2);
      wait_done(d0, 2000, ok);
      compared++;
      if (!ok) begin mismatched++; $display("[TB] FAIL wr2_timeout: no done within budget"); end
      compared++;
      if (bits_at(0, 8) !== 32'h02 || bits_at(8, 24) !== 32'h0FFFFF || bits_at(32, 16) !== 32'h5AC3) begin
         mismatched++;
         $display("[TB] FAIL wr2_mosi: got %h %h %h required 02 0fffff 5ac3",
                  bits_at(0, 8), bits_at(8, 24), bits_at(32, 16));
      end
      compared++;
      if (wr_ack_cnt - a0 !== 2 || ack_addr_log[a0 & 63] !== 20'hFFFFF || ack_addr_log[(a0 + 1) & 63] !== 20'h00000) begin
         mismatched++;
         $display("[TB] FAIL wr2_ack: acks %0d addr %h %h required 2 fffff 00000",
                  wr_ack_cnt - a0, ack_addr_log[a0 & 63], ack_addr_log[(a0 + 1) & 63]);
      end
      compared++;
      if (cur_addr !== 20'h00001) begin
         mismatched++; $display("[TB] FAIL wr2_end_addr: got %h required 00001", cur_addr);
      end
   endtask

   task automatic test_reset_abort();
      int d0 = done_cnt, r0;
      bit ok;
      bit reached = 1'b0;
      for (int i = 0; i < 4; i++) slave_words[i] = 8'h00;
      issue(1'b0, 1'b1, 20'h00040, 5'd3);
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (rx_bits >= 36) begin
            reached = 1'b1;
            break;
         end
      end
      compared++;
      if (!reached) begin mismatched++; $display("[TB] FAIL abort_reach_data: rx_bits %0d required >=36", rx_bits); end
      #2 reset = 1'b0;
      #1;
      compared++;
      if ({spi_cs_n, spi_sclk, busy} !== 3'b100) begin
         mismatched++;
         $display("[TB] FAIL abort_pins: cs_n/sclk/busy %b required 100", {spi_cs_n, spi_sclk, busy});
      end
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (5) @(negedge clk);
      #1;
      compared++;
      if (done_cnt - d0 !== 0) begin
         mismatched++; $display("[TB] FAIL abort_no_done: got %0d required 0", done_cnt - d0);
      end
      slave_words[0] = 8'h3C;
      r0 = rd_valid_cnt;
      issue(1'b0, 1'b1, 20'h00050, 5'd1);
      wait_done(d0, 2000, ok);
      compared++;
      if (!ok || rd_valid_cnt - r0 !== 1 || rd_log[r0 & 63] !== 8'h3C) begin
         mismatched++;
         $display("[TB] FAIL abort_recover: ok %0d pulses %0d data %h required 1 1 3c",
                  ok, rd_valid_cnt - r0, rd_log[r0 & 63]);
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         wr_words[i]    = 8'h00;
         slave_words[i] = 8'h00;
      end
      test_reset();
      test_write_single();
      test_read_single();
      test_burst_read();
      test_reject();
      test_busy_ignore();
      test_burst_write_wrap();
      test_reset_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
